// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The byte stream is a 4-byte length header, then 4-byte little-endian words.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CHK,
        DONE
    } state_t;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and memory write port of the loader.
// The master modport is the loader side; the slave modport is the stream source plus the memory side.
interface imem_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);

    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            in_data;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/imem_byte_assembler.sv
// Little-endian byte-to-word shift register with a 2-bit byte counter.
// The same assembler handles the length header, the data words and the checksum trailer.
module imem_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          byte_en,
    input  logic [7:0]                    byte_in,
    output logic [1:0]                    byte_cnt,
    output logic [8*BYTES_PER_WORD-1:0]   word_next
);

    logic [8*BYTES_PER_WORD-1:0] shift_q;

    // Each new byte enters at the top, so after four bytes the first one sits in [7:0].
    assign word_next = {byte_in, shift_q[8*BYTES_PER_WORD-1:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            shift_q  <= '0;
            byte_cnt <= '0;
        end else if (byte_en) begin
            shift_q  <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory, one word per write strobe.
// Define IMEM_LOADER_CHECKSUM_EN to accept and verify a 4-byte sum trailer after the data words.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_SIZE   = 512,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          chk_err
);

    localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t TAIL_STATE = CHK;
`else
    localparam state_t TAIL_STATE = DONE;
`endif

    state_t                state, state_nxt;
    logic                  in_ready, wr_en, clear;
    logic                  byte_fire, len_done, word_done;
    logic [1:0]            byte_cnt;
    logic [31:0]           word_next;
    logic [31:0]           n_words, word_idx;
    logic [ADDR_WIDTH-1:0] addr_sum, wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    assign in_ready  = (state == LEN) || (state == DATA) || (state == CHK);
    assign byte_fire = bus.in_valid && in_ready;
    assign len_done  = byte_fire && (byte_cnt == 2'(HDR_BYTES - 1));
    assign word_done = byte_fire && (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign addr_sum  = BASE_ADDR + (ADDR_WIDTH'(word_idx) << 2);

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    imem_byte_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .byte_en   (byte_fire),
        .byte_in   (bus.in_data),
        .byte_cnt  (byte_cnt),
        .word_next (word_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        wr_en     = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LEN;
                    clear     = 1'b1;
                end
            end
            LEN: begin
                busy = 1'b1;
                if (len_done) begin
                    if (word_next == 32'd0)          state_nxt = TAIL_STATE;
                    else if (word_next > MEM_WORDS)  state_nxt = DONE;
                    else                             state_nxt = DATA;
                end
            end
            DATA: begin
                busy = 1'b1;
                if (word_done) state_nxt = WRITE;
            end
            WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (word_idx + 32'd1 < n_words) state_nxt = DATA;
                else                            state_nxt = TAIL_STATE;
            end
            CHK: begin
                if (word_done) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = LEN;
                    clear     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // An oversized length raises err and skips straight to DONE, so word_idx stays below MEM_SIZE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_words   <= '0;
            word_idx  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err       <= 1'b0;
        end else begin
            if (clear) begin
                n_words  <= '0;
                word_idx <= '0;
                err      <= 1'b0;
            end
            if (state == LEN && len_done) begin
                n_words <= word_next;
                err     <= (word_next > MEM_WORDS);
            end
            if (state == DATA && word_done) begin
                wr_addr_q <= {addr_sum[ADDR_WIDTH-1:2], 2'b00};
                wr_data_q <= DATA_WIDTH'(word_next);
            end
            if (state == WRITE) word_idx <= word_idx + 32'd1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            chk_err <= 1'b0;
        end else if (clear) begin
            sum_q   <= '0;
            chk_err <= 1'b0;
        end else begin
            if (state == DATA && word_done) sum_q   <= sum_q + word_next;
            if (state == CHK && word_done)  chk_err <= (word_next != sum_q);
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; with IMEM_LOADER_CHECKSUM_EN defined it also sends
// trailers and checks chk_err.
module tb_imem_loader;
    import imem_loader_pkg::*;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy, done, err, chk_err;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int start_cyc = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];
    logic [31:0] model_sum;

    imem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    imem_loader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .MEM_SIZE   (512),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .chk_err (chk_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            log_addr.push_back(bus.wr_addr);
            log_data.push_back(bus.wr_data);
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Offers one byte and returns at the negedge after the edge that accepted it.
    task automatic applyStimulus(input logic [7:0] b);
        bit rdy;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 50; i++) begin
            rdy = bus.in_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        errors++;
        $display("[TB] FAIL handshake: byte %02h observed=not accepted expected=accepted", b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8]);
    endtask

    task automatic send_trailer(input logic [31:0] w);
        if (CHK_EN) send_word(w);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
        checkOutput(tag, done, 1);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Asynchronous reset, checked before any clock edge
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_wr_en",    bus.wr_en,    0);
        checkOutput("rst_busy",     busy,         0);
        checkOutput("rst_done",     done,         0);
        checkOutput("rst_err",      err,          0);
        checkOutput("rst_chk_err",  chk_err,      0);
        checkOutput("rst_wr_addr",  bus.wr_addr,  0);
        checkOutput("rst_wr_data",  bus.wr_data,  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_in_ready", bus.in_ready, 0);

        // Two-word load
        $display("[TB] two-word load");
        clear_log();
        pulse_start();
        checkOutput("len_busy",     busy,         1);
        checkOutput("len_in_ready", bus.in_ready, 1);
        send_word(32'h0000_0002);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        send_trailer(32'h0010_00A6);
        wait_done("a_done");
        repeat (2) @(negedge clk);
        checkOutput("a_nwrites",   log_addr.size(), 2);
        checkOutput("a_addr0",     log_addr[0], 32'h0);
        checkOutput("a_data0",     log_data[0], 32'h0000_0013);
        checkOutput("a_addr1",     log_addr[1], 32'h4);
        checkOutput("a_data1",     log_data[1], 32'h0010_0093);
        checkOutput("a_lat0",      log_cyc[0] - start_cyc, 8);
        checkOutput("a_lat1",      log_cyc[1] - start_cyc, 13);
        checkOutput("a_err",       err,          0);
        checkOutput("a_busy",      busy,         0);
        checkOutput("a_in_ready",  bus.in_ready, 0);
        checkOutput("a_wr_en",     bus.wr_en,    0);
        checkOutput("a_hold_addr", bus.wr_addr,  32'h4);
        checkOutput("a_hold_data", bus.wr_data,  32'h0010_0093);
        checkOutput("a_chk_err",   chk_err,      0);

        // Length one past MEM_SIZE
        $display("[TB] oversize length");
        clear_log();
        pulse_start();
        send_word(32'h0000_0201);
        wait_done("b_done");
        repeat (3) @(negedge clk);
        checkOutput("b_err",     err,             1);
        checkOutput("b_nwrites", log_addr.size(), 0);

        // Zero-length load; start also clears the sticky err
        $display("[TB] zero length");
        pulse_start();
        checkOutput("c_err_cleared", err, 0);
        send_word(32'h0000_0000);
        send_trailer(32'h0000_0000);
        wait_done("c_done");
        repeat (2) @(negedge clk);
        checkOutput("c_nwrites", log_addr.size(), 0);
        checkOutput("c_err",     err,             0);
        checkOutput("c_chk_err", chk_err,         0);

        // Seven-cycle stall after the second byte of a word
        $display("[TB] mid-word stall");
        clear_log();
        pulse_start();
        send_word(32'h0000_0001);
        applyStimulus(8'h93);
        applyStimulus(8'h00);
        repeat (7) @(negedge clk);
        applyStimulus(8'h10);
        applyStimulus(8'h00);
        send_trailer(32'h0010_0093);
        wait_done("d_done");
        repeat (2) @(negedge clk);
        checkOutput("d_nwrites", log_addr.size(), 1);
        checkOutput("d_addr",    log_addr[0], 32'h0);
        checkOutput("d_data",    log_data[0], 32'h0010_0093);
        checkOutput("d_lat",     log_cyc[0] - start_cyc, 15);

        // start pulsed during DATA is ignored
        $display("[TB] start during DATA");
        clear_log();
        pulse_start();
        send_word(32'h0000_0002);
        applyStimulus(8'hAA);
        pulse_start();
        checkOutput("e_busy", busy, 1);
        applyStimulus(8'hBB);
        applyStimulus(8'hCC);
        applyStimulus(8'hDD);
        send_word(32'h5566_7788);
        send_trailer(32'h3333_3332);
        wait_done("e_done");
        repeat (2) @(negedge clk);
        checkOutput("e_nwrites", log_addr.size(), 2);
        checkOutput("e_data0",   log_data[0], 32'hDDCC_BBAA);
        checkOutput("e_addr1",   log_addr[1], 32'h4);
        checkOutput("e_data1",   log_data[1], 32'h5566_7788);

        // Full-depth load at exactly MEM_SIZE words
        $display("[TB] full-depth load");
        clear_log();
        model_sum = 32'h0;
        pulse_start();
        send_word(32'd512);
        for (int i = 0; i < 512; i++) begin
            model_sum = model_sum + (32'(i) ^ 32'hA5A5_0000);
            send_word(32'(i) ^ 32'hA5A5_0000);
        end
        send_trailer(model_sum);
        wait_done("g_done");
        repeat (2) @(negedge clk);
        checkOutput("g_err",       err,             0);
        checkOutput("g_nwrites",   log_addr.size(), 512);
        checkOutput("g_last_addr", log_addr[511],   32'h7FC);
        checkOutput("g_last_data", log_data[511],   32'hA5A5_01FF);
        checkOutput("g_chk_err",   chk_err,         0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] checksum trailer");
        pulse_start();
        send_word(32'd2);
        send_word(32'h1);
        send_word(32'h2);
        send_word(32'h3);
        wait_done("h_done_good");
        checkOutput("h_chk_good", chk_err, 0);
        pulse_start();
        send_word(32'd2);
        send_word(32'h1);
        send_word(32'h2);
        send_word(32'h4);
        wait_done("h_done_bad");
        checkOutput("h_chk_bad", chk_err, 1);
        pulse_start();
        checkOutput("h_chk_cleared", chk_err, 0);
        send_word(32'd0);
        send_word(32'd0);
        wait_done("h_done_zero");
`endif

        // Reset during the third data word abandons the load
        $display("[TB] reset mid-load");
        clear_log();
        pulse_start();
        send_word(32'd4);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        applyStimulus(8'h33);
        applyStimulus(8'h33);
        checkOutput("f_pre_nwrites", log_addr.size(), 2);
        checkOutput("f_pre_busy",    busy,            1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("f_rst_busy",     busy,         0);
        checkOutput("f_rst_in_ready", bus.in_ready, 0);
        checkOutput("f_rst_wr_en",    bus.wr_en,    0);
        checkOutput("f_rst_done",     done,         0);
        checkOutput("f_rst_wr_addr",  bus.wr_addr,  0);
        checkOutput("f_rst_wr_data",  bus.wr_data,  0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h44;
        repeat (12) @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("f_post_nwrites", log_addr.size(), 0);
        checkOutput("f_post_busy",    busy,            0);
        checkOutput("f_post_done",    done,            0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of the write port.
REQ-003 SHALL have parameter MEM_SIZE, default 512, instruction memory depth in words.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of the first written word, word-aligned.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 start  input  1  one-cycle pulse arming a load; ignored unless in IDLE or DONE.
REQ-008 in_valid / in_ready / in_data  input / output / input  1 / 1 / 8  byte stream; a byte transfers when in_valid and in_ready are high on a rising edge.
REQ-009 wr_en  output  1  one-cycle write strobe to the instruction memory write port.
REQ-010 wr_addr  output  ADDR_WIDTH  word-aligned byte address; bits [1:0] always 0.
REQ-011 wr_data  output  DATA_WIDTH  word to write.
REQ-012 busy  output  1  high in LEN, DATA and WRITE.
REQ-013 done  output  1  high in DONE.
REQ-014 err  output  1  sticky error flag, cleared by start.
REQ-015 chk_err  output  1  checksum mismatch flag; constant 0 when checksum support is compiled out.

Function
REQ-016 Stream format: 4-byte little-endian word count N, then N words, each 4 bytes little-endian (first byte = bits [7:0]).
REQ-017 States: IDLE, LEN, DATA, WRITE, CHK, DONE; start moves IDLE/DONE -> LEN and clears err, chk_err, byte and word counters.
REQ-018 in_ready is high only in LEN, DATA and CHK; low in IDLE, WRITE and DONE.
REQ-019 LEN -> DATA after the 4th length byte; N = 0 goes directly to DONE (or CHK when enabled) with no writes.
REQ-020 N > MEM_SIZE: err set, no writes issued, state -> DONE.
REQ-021 DATA -> WRITE on the 4th byte of a word; WRITE lasts exactly one cycle with wr_en = 1, wr_addr = BASE_ADDR + 4*k for word index k, wr_data = assembled word.
REQ-022 Latency: wr_en asserts the cycle after the 4th byte handshake; maximum throughput is one word per 5 cycles.
REQ-023 After WRITE: k+1 < N -> DATA; else DONE (or CHK when enabled).
REQ-024 wr_addr arithmetic is modulo 2^ADDR_WIDTH; k never exceeds MEM_SIZE-1 because of REQ-020.
REQ-025 wr_en is 0 in every state except WRITE; wr_addr and wr_data hold their last values otherwise.
REQ-026 in_valid low mid-word stalls without losing partial bytes; start during LEN, DATA, WRITE or CHK is ignored.

Reset
REQ-027 rst_n low SHALL force state IDLE and in_ready, wr_en, busy, done, err and chk_err to 0, and wr_addr, wr_data and all counters to 0, immediately and regardless of clk.
REQ-028 Reset mid-load SHALL abandon the load; no further wr_en until a new start.

Configuration
REQ-029 Macro IMEM_LOADER_CHECKSUM_EN: when defined, CHK state accepts a 4-byte little-endian trailer; chk_err = (trailer != sum of all N words mod 2^32), then state -> DONE.
REQ-030 Without IMEM_LOADER_CHECKSUM_EN, CHK is unreachable, no trailer is consumed, and chk_err is tied 0.

Structure
REQ-031 Package imem_loader_pkg SHALL hold the state enum typedef, the HDR_BYTES = 4 constant and the BYTES_PER_WORD = 4 constant.
REQ-032 Sub-module imem_byte_assembler SHALL contain the little-endian byte-to-word shift register and the 2-bit byte counter, reused for length, data and trailer.

Verification
REQ-033 Start, stream 02 00 00 00, 13 00 00 00, 93 00 10 00 -> wr_en twice: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093; done = 1, err = 0.
REQ-034 Length 0x00000201 with MEM_SIZE = 512 -> err = 1, done = 1, zero wr_en pulses.
REQ-035 in_valid dropped for 7 cycles after the 2nd byte of a word -> same wr_data as an unstalled stream, wr_en delayed 7 cycles.
REQ-036 rst_n low during the 3rd data word -> all outputs 0 asynchronously; subsequent bytes with no start produce no writes.
REQ-037 With IMEM_LOADER_CHECKSUM_EN, words 0x1 and 0x2 plus trailer 0x3 -> chk_err = 0; trailer 0x4 -> chk_err = 1.
REQ-038 start pulsed during DATA -> ignored; load completes with the original N.
